// File: rtl/vx_commit_arbiter.sv
// Round-robin commit arbiter: serializes execute-unit results onto the single writeback port,
// holding the grant across multi-packet results. Optional stall counter: VX_COMMIT_STALL_CTR_EN.
module vx_commit_arbiter #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int UUID_BITS   = 44,
  parameter int NR_BITS     = 5,
  parameter int XLEN        = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  output logic [NUM_REQS-1:0]                 req_ready,
  input  logic [NUM_REQS-1:0]                 req_wb,
  input  logic [NUM_REQS-1:0]                 req_eop,
  input  logic [NUM_REQS*UUID_BITS-1:0]       req_uuid,
  input  logic [NUM_REQS*NW_BITS-1:0]         req_wid,
  input  logic [NUM_REQS*32-1:0]              req_PC,
  input  logic [NUM_REQS*NUM_THREADS-1:0]     req_tmask,
  input  logic [NUM_REQS*NR_BITS-1:0]         req_rd,
  input  logic [NUM_REQS*NUM_THREADS*XLEN-1:0] req_data,
  output logic                                wb_valid,
  output logic [UUID_BITS-1:0]                wb_uuid,
  output logic [NW_BITS-1:0]                  wb_wid,
  output logic [31:0]                         wb_PC,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [NR_BITS-1:0]                  wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]         wb_data,
  output logic                                wb_eop
`ifdef VX_COMMIT_STALL_CTR_EN
  ,
  output logic [63:0]                         perf_wb_stalls
`endif
);

  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int DW    = NUM_THREADS * XLEN;
  localparam logic [IDX_W:0]   NREQ_W = (IDX_W+1)'(NUM_REQS);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(NUM_REQS - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic                 wb_valid_q;
  logic [UUID_BITS-1:0] wb_uuid_q;
  logic [NW_BITS-1:0]   wb_wid_q;
  logic [31:0]          wb_PC_q;
  logic [NUM_THREADS-1:0] wb_tmask_q;
  logic [NR_BITS-1:0]   wb_rd_q;
  logic [DW-1:0]        wb_data_q;
  logic                 wb_eop_q;

  logic [NUM_REQS-1:0] cand;
  logic [NUM_REQS-1:0] grant_oh;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W:0]      pos;
  logic                grant_eop;

  assign cand = req_valid & req_wb;

  // While locked only the lock owner is eligible; otherwise search from rr_ptr with wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = cand[lock_idx_q];
      grant_idx = lock_idx_q;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
        if (pos >= NREQ_W) pos = pos - NREQ_W;
        if (!grant_vld && cand[pos[IDX_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = pos[IDX_W-1:0];
        end
      end
    end
  end

  assign grant_oh  = grant_vld ? (NUM_REQS'(1) << grant_idx) : '0;
  assign req_ready = (req_valid & ~req_wb) | grant_oh;
  assign grant_eop = req_eop[grant_idx];

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_vld) begin
      if (grant_eop) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx == LAST_W) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_uuid_q  <= '0;
      wb_wid_q   <= '0;
      wb_PC_q    <= '0;
      wb_tmask_q <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_eop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= grant_vld;
      // Fields hold their last value between packets; only wb_valid marks a new one.
      if (grant_vld) begin
        wb_uuid_q  <= req_uuid[grant_idx*UUID_BITS +: UUID_BITS];
        wb_wid_q   <= req_wid[grant_idx*NW_BITS +: NW_BITS];
        wb_PC_q    <= req_PC[grant_idx*32 +: 32];
        wb_tmask_q <= req_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
        wb_rd_q    <= req_rd[grant_idx*NR_BITS +: NR_BITS];
        wb_data_q  <= req_data[grant_idx*DW +: DW];
        wb_eop_q   <= grant_eop;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_uuid  = wb_uuid_q;
  assign wb_wid   = wb_wid_q;
  assign wb_PC    = wb_PC_q;
  assign wb_tmask = wb_tmask_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_eop   = wb_eop_q;

`ifdef VX_COMMIT_STALL_CTR_EN
  logic [63:0] stalls_q, stalls_d;

  // A cycle stalls when some writeback candidate is left waiting.
  assign stalls_d = (|(cand & ~grant_oh)) ? stalls_q + 64'd1 : stalls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stalls_q <= '0;
    else        stalls_q <= stalls_d;
  end

  assign perf_wb_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter: round-robin order, locking, sinks, reset and field fidelity.
module tb_vx_commit_arbiter;

  localparam int N  = 5;
  localparam int NT = 4;
  localparam int NW = 2;
  localparam int UB = 44;
  localparam int NR = 5;
  localparam int XL = 32;
  localparam int DW = NT * XL;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid, req_ready, req_wb, req_eop;
  logic [N*UB-1:0]      req_uuid;
  logic [N*NW-1:0]      req_wid;
  logic [N*32-1:0]      req_PC;
  logic [N*NT-1:0]      req_tmask;
  logic [N*NR-1:0]      req_rd;
  logic [N*DW-1:0]      req_data;
  logic                 wb_valid, wb_eop;
  logic [UB-1:0]        wb_uuid;
  logic [NW-1:0]        wb_wid;
  logic [31:0]          wb_PC;
  logic [NT-1:0]        wb_tmask;
  logic [NR-1:0]        wb_rd;
  logic [DW-1:0]        wb_data;
`ifdef VX_COMMIT_STALL_CTR_EN
  logic [63:0]          perf_wb_stalls;
  logic [63:0]          perf_base;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  vx_commit_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb), .req_eop(req_eop),
    .req_uuid(req_uuid), .req_wid(req_wid), .req_PC(req_PC), .req_tmask(req_tmask),
    .req_rd(req_rd), .req_data(req_data),
    .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_PC(wb_PC),
    .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop)
`ifdef VX_COMMIT_STALL_CTR_EN
    , .perf_wb_stalls(perf_wb_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dflt_data(input int i);
    logic [DW-1:0] d;
    for (int l = 0; l < NT; l++) d[l*XL +: XL] = 32'hA000_0000 + 32'(i*16 + l);
    return d;
  endfunction

  task automatic set_src(input int i, input logic v, input logic wb, input logic eop);
    req_valid[i]            = v;
    req_wb[i]               = wb;
    req_eop[i]              = eop;
    req_uuid[i*UB +: UB]    = UB'(100 + i);
    req_wid[i*NW +: NW]     = NW'(i);
    req_PC[i*32 +: 32]      = 32'h1000 + 32'(4*i);
    req_tmask[i*NT +: NT]   = NT'(i + 1);
    req_rd[i*NR +: NR]      = NR'(i + 1);
    req_data[i*DW +: DW]    = dflt_data(i);
  endtask

  task automatic clr_all();
    req_valid = '0; req_wb = '0; req_eop = '0;
  endtask

  // Expect the writeback port to carry source i's default packet.
  task automatic chk_src(input string tag, input int i, input logic eop);
    chk({tag, ".valid"}, 128'(wb_valid), 128'(1'b1));
    chk({tag, ".rd"},    128'(wb_rd),    128'(NR'(i + 1)));
    chk({tag, ".uuid"},  128'(wb_uuid),  128'(UB'(100 + i)));
    chk({tag, ".PC"},    128'(wb_PC),    128'(32'h1000 + 32'(4*i)));
    chk({tag, ".data"},  128'(wb_data),  128'(dflt_data(i)));
    chk({tag, ".eop"},   128'(wb_eop),   128'(eop));
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0; req_wb = '0; req_eop = '0;
    req_uuid = '0; req_wid = '0; req_PC = '0; req_tmask = '0; req_rd = '0; req_data = '0;
    #1;
    chk("rst.wb_valid", 128'(wb_valid), 128'(1'b0));
    chk("rst.wb_data",  128'(wb_data),  128'(0));
    chk("rst.wb_rd",    128'(wb_rd),    128'(0));
    chk("rst.ready",    128'(req_ready), 128'(5'b00000));
`ifdef VX_COMMIT_STALL_CTR_EN
    chk("rst.perf", 128'(perf_wb_stalls), 128'(0));
`endif
    set_src(3, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rst.sink_ready", 128'(req_ready), 128'(5'b01000));
    clr_all();
    tick(); tick();
    reset = 1'b1;
    tick();

    // Round robin over all five sources: 0,1,2,3,4,0
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d.ready", k), 128'(req_ready), 128'(5'b1 << (k % N)));
      tick();
      chk_src($sformatf("rr%0d", k), k % N, 1'b1);
    end
    clr_all();
    tick();
    chk("rr.idle", 128'(wb_valid), 128'(1'b0));

    // Source 1 three-packet burst while 0 and 2 wait; rr_ptr is 1 here
    set_src(0, 1'b1, 1'b1, 1'b1);
    set_src(2, 1'b1, 1'b1, 1'b1);
    for (int p = 0; p < 3; p++) begin
      set_src(1, 1'b1, 1'b1, (p == 2));
      #1;
      chk($sformatf("lk%0d.ready", p), 128'(req_ready), 128'(5'b00010));
      tick();
      chk_src($sformatf("lk%0d", p), 1, (p == 2));
    end
    req_valid[1] = 1'b0;
    #1;
    chk("lk.after.ready", 128'(req_ready), 128'(5'b00100));
    tick();
    chk_src("lk.src2", 2, 1'b1);
    req_valid[2] = 1'b0;
    #1;
    chk("lk.src0.ready", 128'(req_ready), 128'(5'b00001));
    tick();
    chk_src("lk.src0", 0, 1'b1);
    clr_all();
    tick();

    // Sink on source 3 alongside a writeback from source 0
    set_src(0, 1'b1, 1'b1, 1'b1);
    set_src(3, 1'b1, 1'b0, 1'b1);
    #1;
    chk("sink.ready", 128'(req_ready), 128'(5'b01001));
    tick();
    chk_src("sink", 0, 1'b1);
    clr_all();
    tick();
    chk("sink.idle", 128'(wb_valid), 128'(1'b0));

    // Lock on source 4 which then idles while source 0 waits
    set_src(4, 1'b1, 1'b1, 1'b0);
    #1;
    chk("l4.ready", 128'(req_ready), 128'(5'b10000));
    tick();
    chk_src("l4.first", 4, 1'b0);
`ifdef VX_COMMIT_STALL_CTR_EN
    perf_base = perf_wb_stalls;
`endif
    req_valid[4] = 1'b0;
    set_src(0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("l4.wait%0d.ready", c), 128'(req_ready), 128'(5'b00000));
      tick();
      chk($sformatf("l4.wait%0d.valid", c), 128'(wb_valid), 128'(1'b0));
    end
    set_src(4, 1'b1, 1'b1, 1'b1);
    #1;
    chk("l4.last.ready", 128'(req_ready), 128'(5'b10000));
    tick();
    chk_src("l4.last", 4, 1'b1);
    req_valid[4] = 1'b0;
    #1;
    chk("l4.src0.ready", 128'(req_ready), 128'(5'b00001));
    tick();
    chk_src("l4.src0", 0, 1'b1);
`ifdef VX_COMMIT_STALL_CTR_EN
    chk("l4.perf", 128'(perf_wb_stalls - perf_base), 128'(4));
`endif
    clr_all();
    tick();

    // Reset while locked on source 2 with a packet on the output
    set_src(2, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rl.ready", 128'(req_ready), 128'(5'b00100));
    tick();
    chk("rl.valid", 128'(wb_valid), 128'(1'b1));
    reset = 1'b0;
    #1;
    chk("rl.rst_valid", 128'(wb_valid), 128'(1'b0));
    chk("rl.rst_rd",    128'(wb_rd),    128'(0));
`ifdef VX_COMMIT_STALL_CTR_EN
    chk("rl.perf", 128'(perf_wb_stalls), 128'(0));
`endif
    set_src(0, 1'b1, 1'b1, 1'b1);
    set_src(2, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rl.ready0", 128'(req_ready), 128'(5'b00001));
    #2;
    reset = 1'b1;
    tick();
    chk_src("rl.src0", 0, 1'b1);
    clr_all();
    tick();

    // Field fidelity on a lone source 2, first without then with eop
    for (int p = 0; p < 2; p++) begin
      set_src(2, 1'b1, 1'b1, (p == 1));
      req_uuid[2*UB +: UB] = 44'h123_4567_89AB;
      req_wid[2*NW +: NW]  = 2'd3;
      req_PC[2*32 +: 32]   = 32'h8000_0040;
      req_tmask[2*NT +: NT] = 4'b1010;
      req_rd[2*NR +: NR]   = 5'd7;
      req_data[2*DW +: DW] = {32'h3, 32'h2, 32'h1, 32'hDEADBEEF};
      #1;
      chk($sformatf("fld%0d.ready", p), 128'(req_ready), 128'(5'b00100));
      tick();
      chk($sformatf("fld%0d.valid", p), 128'(wb_valid), 128'(1'b1));
      chk($sformatf("fld%0d.uuid", p),  128'(wb_uuid),  128'(44'h123_4567_89AB));
      chk($sformatf("fld%0d.wid", p),   128'(wb_wid),   128'(2'd3));
      chk($sformatf("fld%0d.PC", p),    128'(wb_PC),    128'(32'h8000_0040));
      chk($sformatf("fld%0d.tmask", p), 128'(wb_tmask), 128'(4'b1010));
      chk($sformatf("fld%0d.rd", p),    128'(wb_rd),    128'(5'd7));
      chk($sformatf("fld%0d.data", p),  128'(wb_data),  {32'h3, 32'h2, 32'h1, 32'hDEADBEEF});
      chk($sformatf("fld%0d.eop", p),   128'(wb_eop),   128'(p == 1));
    end
    clr_all();
    tick();
    chk("end.idle", 128'(wb_valid), 128'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vx_commit_arbiter.md
# vx_commit_arbiter

Collects completed instructions from the execute units (ALU, LSU, CSR, FPU, GPU) and serializes them onto the single register-file writeback interface that the issue stage's GPR file and scoreboard consume. It is the producer end of `writeback_if`. It arbitrates round-robin, holds a grant across multi-packet results until end-of-packet, and registers the output.

## Interface
- `NUM_REQS`, 5, number of commit sources (index 0=ALU, 1=LSU, 2=CSR, 3=FPU, 4=GPU).
- `NUM_THREADS`, 4, lanes per warp.
- `NW_BITS`, 2, warp-id width.
- `UUID_BITS`, 44, instruction uuid width.
- `NR_BITS`, 5, register index width.
- `XLEN`, 32, data width per lane.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQS  commit packet valid per source.
- `req_ready`  out  NUM_REQS  commit packet accepted per source.
- `req_wb`  in  NUM_REQS  packet writes the register file.
- `req_eop`  in  NUM_REQS  last packet of the instruction.
- `req_uuid`  in  NUM_REQS*UUID_BITS  per-source uuid, flattened, source 0 in LSBs.
- `req_wid`  in  NUM_REQS*NW_BITS  warp id.
- `req_PC`  in  NUM_REQS*32  instruction PC.
- `req_tmask`  in  NUM_REQS*NUM_THREADS  thread mask.
- `req_rd`  in  NUM_REQS*NR_BITS  destination register.
- `req_data`  in  NUM_REQS*NUM_THREADS*XLEN  per-lane result.
- `wb_valid`, `wb_uuid`, `wb_wid`, `wb_PC`, `wb_tmask`, `wb_rd`, `wb_data`, `wb_eop`  out  (single-source widths)  registered writeback packet; no backpressure.
- `perf_wb_stalls`  out  64  present only with `VX_COMMIT_STALL_CTR_EN`.

## Operation
- Packets with `req_wb=0` are sunk: `req_ready[i]=req_valid[i] & ~req_wb[i]` combinationally, independent of arbitration, never appear on output.
- Packets with `req_wb=1` are candidates. Exactly one candidate granted per cycle; `req_ready[i]=1` only for the granted index.
- Round-robin: pointer `rr_ptr` (reset 0). Search starts at `rr_ptr`, wraps modulo NUM_REQS. On a granted packet with `eop=1`, `rr_ptr <= grant+1` (wrap NUM_REQS-1 -> 0).
- Lock: granted packet with `eop=0` sets `locked=1`, `lock_idx=grant`. While locked only `lock_idx` may be granted; other candidates wait even if lock source is idle. Lock clears on the fire of `lock_idx` packet with `eop=1`.
- State machine: IDLE (no lock) -> LOCKED on eop=0 grant; LOCKED -> IDLE on eop=1 fire of lock_idx; LOCKED stays otherwise.
- Output register loads all fields of the granted packet on fire; `wb_valid` high for exactly one cycle per fired packet.
- `req_ready` never depends on output state (output always accepted).

## Timing
- Latency 1 cycle: fire at edge N -> `wb_valid=1` with its fields during cycle N+1.
- Throughput: one wb packet per cycle sustained; sunk packets fire in parallel in the same cycle.
- Reset (asserted low, any time, asynchronous): `wb_valid=0`, all `wb_*` fields 0, `rr_ptr=0`, `locked=0`, `lock_idx=0`, `perf_wb_stalls=0`; `req_ready` follows combinational rules (sinks still acknowledged; grants start from index 0 after deassert).
- Reset mid-lock: lock dropped; the partially written instruction is the source unit's concern.
- `req_valid` may drop without fire; no grant is recorded unless valid&ready.

## Configuration
- `VX_COMMIT_STALL_CTR_EN` defined: `perf_wb_stalls` 64-bit counter increments by 1 each cycle in which at least one source has `req_valid&req_wb` and is not granted; wraps at 2^64.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- All five sources valid, wb=1, eop=1 from reset -> grants 0,1,2,3,4,0 on consecutive cycles; `wb_valid` continuous from the cycle after the first fire.
- Source 1 sends 3 packets eop=0,0,1 while source 0 and 2 valid -> outputs source1 x3 uninterrupted, then source 2, then source 0; `rr_ptr=2` after lock release.
- Source 3 wb=0 valid with source 0 wb=1 valid -> both ready same cycle; only source 0 appears on `wb_*`, one cycle later.
- Lock on source 4 (eop=0), source 4 idles 3 cycles while source 0 valid -> no output for 3 cycles; with macro, `perf_wb_stalls` increases by 3 (plus cycles until source 0 is granted).
- Assert reset low during locked state with `wb_valid=1` -> immediately `wb_valid=0`; after release, source 0 granted first.
- Single source 2, data lanes 0xDEADBEEF/0x1/0x2/0x3, rd=7, tmask=4'b1010 -> exact same fields on `wb_*` one cycle later, `wb_eop` mirrors input.
